// File: rtl/pitch_score_pkg.sv
// Shared constants and FSM state type for the pitch score sequencer.
package pitch_score_pkg;

  localparam int FREQ_W    = 15;
  localparam int SCORE_W   = 4;
  localparam int SCORE_MAX = 15;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    SCORE,
    ACCUM,
    REPORT
  } pss_state_t;

endpackage

// File: rtl/pitch_score_calc.sv
// Combinational mapping of a sung/reference frequency pair to a 0..15 match
// score: the absolute difference is coarsened by DIFF_SHIFT and subtracted
// from the maximum score, saturating at zero for large misses.
module pitch_score_calc #(
  parameter int FREQ_W     = pitch_score_pkg::FREQ_W,
  parameter int DIFF_SHIFT = 2
) (
  input  logic [FREQ_W-1:0]                  song_freq,
  input  logic [FREQ_W-1:0]                  ref_freq,
  output logic [pitch_score_pkg::SCORE_W-1:0] score
);
  import pitch_score_pkg::*;

  logic [FREQ_W-1:0] diff;
  logic [FREQ_W-1:0] coarse;

  // Unsigned |song - ref|, shifted, then clamped into the score range.
  always_comb begin
    diff   = (song_freq >= ref_freq) ? (song_freq - ref_freq) : (ref_freq - song_freq);
    coarse = diff >> DIFF_SHIFT;
    if (coarse > FREQ_W'(SCORE_MAX)) begin
      score = '0;
    end else begin
      score = SCORE_W'(SCORE_MAX) - coarse[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/pitch_score_sequencer.sv
// Drains the song and reference pitch FIFOs in lockstep, scores each pair and
// publishes the average score of every 2^WINDOW_LOG2-sample window.
// Optional feature macro: PITCH_SCORE_SILENCE_SKIP_EN (drop pairs whose
// reference word is 0, so rests never touch the window).
module pitch_score_sequencer #(
  parameter int FREQ_W      = pitch_score_pkg::FREQ_W,
  parameter int WINDOW_LOG2 = 4,
  parameter int DIFF_SHIFT  = 2,
  parameter int WAIT_MAX    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                song_empty,
  output logic                                song_rd_en,
  input  logic [FREQ_W-1:0]                   song_dout,
  input  logic                                song_valid,
  input  logic                                ref_empty,
  output logic                                ref_rd_en,
  input  logic [FREQ_W-1:0]                   ref_dout,
  input  logic                                ref_valid,
  output logic [pitch_score_pkg::SCORE_W-1:0] score_avg,
  output logic                                score_ready,
  output logic                                seq_error
);
  import pitch_score_pkg::*;

  localparam int SUM_W  = SCORE_W + WINDOW_LOG2;
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  pss_state_t state, next_state;

  logic [FREQ_W-1:0]      song_word;
  logic [FREQ_W-1:0]      ref_word;
  logic [SCORE_W-1:0]     calc_score;
  logic [SCORE_W-1:0]     score_reg;
  logic [SUM_W-1:0]       sum;
  logic [SUM_W-1:0]       new_sum;
  logic [WINDOW_LOG2-1:0] cnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   both_valid;
  logic                   wait_fail;
  logic                   window_full;

  pitch_score_calc #(
    .FREQ_W     (FREQ_W),
    .DIFF_SHIFT (DIFF_SHIFT)
  ) u_calc (
    .song_freq (song_word),
    .ref_freq  (ref_word),
    .score     (calc_score)
  );

  // Shared decode: read-data handshake result, window-full flag, next sum.
  always_comb begin
    both_valid  = song_valid && ref_valid;
    wait_fail   = (state == WAIT) && !both_valid &&
                  (song_valid || ref_valid || (wait_cnt == WAIT_LAST));
    window_full = &cnt;
    new_sum     = sum + SUM_W'(score_reg);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic for the pop / wait / score / accumulate sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (enable && !song_empty && !ref_empty) begin
          next_state = POP;
        end
      end
      POP: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (both_valid) begin
          next_state = SCORE;
        end else if (wait_fail) begin
          next_state = IDLE;
        end
      end
      SCORE: begin
`ifdef PITCH_SCORE_SILENCE_SKIP_EN
        if (ref_word == '0) begin
          next_state = IDLE;
        end else begin
          next_state = ACCUM;
        end
`else
        next_state = ACCUM;
`endif
      end
      ACCUM: begin
        next_state = window_full ? REPORT : IDLE;
      end
      REPORT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered outputs and datapath; strobes are decoded from next_state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      song_rd_en  <= 1'b0;
      ref_rd_en   <= 1'b0;
      score_ready <= 1'b0;
      score_avg   <= '0;
      seq_error   <= 1'b0;
      song_word   <= '0;
      ref_word    <= '0;
      score_reg   <= '0;
      sum         <= '0;
      cnt         <= '0;
      wait_cnt    <= '0;
    end else begin
      song_rd_en  <= (next_state == POP);
      ref_rd_en   <= (next_state == POP);
      score_ready <= (next_state == REPORT);

      if (state == WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if ((state == WAIT) && both_valid) begin
        song_word <= song_dout;
        ref_word  <= ref_dout;
      end

      if (wait_fail) begin
        seq_error <= 1'b1;
      end

      if (state == SCORE) begin
        score_reg <= calc_score;
      end

      if (state == ACCUM) begin
        cnt <= cnt + WINDOW_LOG2'(1);
        if (window_full) begin
          score_avg <= new_sum[SUM_W-1 -: SCORE_W];
          sum       <= '0;
        end else begin
          sum <= new_sum;
        end
      end
    end
  end

endmodule
